mem_bus_arb: RTL and testbench

//  2-master arbiter for the picorv32 native memory bus (valid/ready/addr/wdata/wstrb/rdata).

---
 rtl/mem_bus_arb.sv | 145 ++++++++++++++
 tb/tb_mem_bus_arb.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arb.sv
// Two-master round-robin arbiter for the picorv32 native memory bus; a granted transfer holds the bus until the slave completes it.
// Optional transfer timeout: define MEMARB_TIMEOUT_EN.
module mem_bus_arb #(
  parameter int          TIMEOUT   = 1024,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_mem_valid,
  output logic        m0_mem_ready,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic [31:0] m0_mem_rdata,

  input  logic        m1_mem_valid,
  output logic        m1_mem_ready,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic [31:0] m1_mem_rdata,

  output logic        s_mem_valid,
  input  logic        s_mem_ready,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic [31:0] s_mem_rdata,

  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;

  logic        gnt_m1;
  logic        req_valid;
  logic        done;
  logic [31:0] resp_rdata;

`ifdef MEMARB_TIMEOUT_EN
  localparam int             CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT, ERR_RDATA};
`endif

  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    s_mem_valid  = 1'b0;
    s_mem_addr   = '0;
    s_mem_wdata  = '0;
    s_mem_wstrb  = '0;
    m0_mem_ready = 1'b0;
    m0_mem_rdata = '0;
    m1_mem_ready = 1'b0;
    m1_mem_rdata = '0;
    bus_err      = 1'b0;
    done         = 1'b0;
    resp_rdata   = '0;
    gnt_m1       = (state_q == GNT1);
    req_valid    = gnt_m1 ? m1_mem_valid : m0_mem_valid;
`ifdef MEMARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef MEMARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        // On contention the master not served last wins.
        if (m0_mem_valid && (!m1_mem_valid || last_gnt_q)) begin
          state_d = GNT0;
        end else if (m1_mem_valid) begin
          state_d = GNT1;
        end
      end

      GNT0, GNT1: begin
        s_mem_valid = req_valid;
        s_mem_addr  = gnt_m1 ? m1_mem_addr  : m0_mem_addr;
        s_mem_wdata = gnt_m1 ? m1_mem_wdata : m0_mem_wdata;
        s_mem_wstrb = gnt_m1 ? m1_mem_wstrb : m0_mem_wstrb;

        // A master withdrawing its request is treated as an abort, not a serve.
        if (!req_valid) begin
          state_d = IDLE;
        end else if (s_mem_ready) begin
          done       = 1'b1;
          resp_rdata = s_mem_rdata;
`ifdef MEMARB_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          done        = 1'b1;
          resp_rdata  = ERR_RDATA;
          bus_err     = 1'b1;
          s_mem_valid = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end

        if (done) begin
          state_d    = IDLE;
          last_gnt_d = gnt_m1;
        end
      end

      default: state_d = IDLE;
    endcase

    m0_mem_ready = done & ~gnt_m1;
    m1_mem_ready = done &  gnt_m1;
    m0_mem_rdata = (done & ~gnt_m1) ? resp_rdata : '0;
    m1_mem_rdata = (done &  gnt_m1) ? resp_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
`ifdef MEMARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
`ifdef MEMARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed bench for mem_bus_arb: grant order, bus muxing, abort, timeout and async reset behaviour.
module tb_mem_bus_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_mem_valid, m0_mem_ready;
  logic [31:0] m0_mem_addr, m0_mem_wdata, m0_mem_rdata;
  logic [3:0]  m0_mem_wstrb;
  logic        m1_mem_valid, m1_mem_ready;
  logic [31:0] m1_mem_addr, m1_mem_wdata, m1_mem_rdata;
  logic [3:0]  m1_mem_wstrb;
  logic        s_mem_valid, s_mem_ready;
  logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [3:0]  s_mem_wstrb;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_arb #(.TIMEOUT(16), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_mem_valid(m0_mem_valid), .m0_mem_ready(m0_mem_ready), .m0_mem_addr(m0_mem_addr),
    .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb), .m0_mem_rdata(m0_mem_rdata),
    .m1_mem_valid(m1_mem_valid), .m1_mem_ready(m1_mem_ready), .m1_mem_addr(m1_mem_addr),
    .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb), .m1_mem_rdata(m1_mem_rdata),
    .s_mem_valid(s_mem_valid), .s_mem_ready(s_mem_ready), .s_mem_addr(s_mem_addr),
    .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb), .s_mem_rdata(s_mem_rdata),
    .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    m0_mem_valid = 0; m0_mem_addr = 0; m0_mem_wdata = 0; m0_mem_wstrb = 0;
    m1_mem_valid = 0; m1_mem_addr = 0; m1_mem_wdata = 0; m1_mem_wstrb = 0;
    s_mem_ready  = 0; s_mem_rdata = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    m0_mem_addr = 32'h1234; m0_mem_wstrb = 4'hF; s_mem_rdata = 32'hFFFFFFFF;
    #23;
    checks++;
    if ({s_mem_valid, s_mem_addr, s_mem_wdata, s_mem_wstrb} !== 69'd0) begin
      errors++; $display("FAIL reset_slave_bus: got v=%b a=%h w=%h s=%h, want all 0",
                         s_mem_valid, s_mem_addr, s_mem_wdata, s_mem_wstrb);
    end
    checks++;
    if ({m0_mem_ready, m1_mem_ready, m0_mem_rdata, m1_mem_rdata, bus_err} !== 67'd0) begin
      errors++; $display("FAIL reset_master_side: got r0=%b r1=%b d0=%h d1=%h err=%b, want all 0",
                         m0_mem_ready, m1_mem_ready, m0_mem_rdata, m1_mem_rdata, bus_err);
    end
    tick();
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_read_m0();
    m0_mem_valid = 1; m0_mem_addr = 32'h100; m0_mem_wstrb = 0;
    #1;
    checks++;
    if (s_mem_valid !== 1'b0) begin
      errors++; $display("FAIL rd_grant_latency: s_mem_valid=%b want 0", s_mem_valid);
    end
    tick(); #1;
    checks++;
    if (s_mem_valid !== 1'b1 || s_mem_addr !== 32'h100 || s_mem_wstrb !== 4'h0) begin
      errors++; $display("FAIL rd_slave_req: v=%b a=%h s=%h want 1/00000100/0",
                         s_mem_valid, s_mem_addr, s_mem_wstrb);
    end
    tick(); #1;
    checks++;
    if (m0_mem_ready !== 1'b0) begin
      errors++; $display("FAIL rd_early_ready: m0_mem_ready=%b want 0", m0_mem_ready);
    end
    tick();
    s_mem_ready = 1; s_mem_rdata = 32'h12345678;
    #1;
    checks++;
    if (m0_mem_ready !== 1'b1 || m0_mem_rdata !== 32'h12345678) begin
      errors++; $display("FAIL rd_complete: ready=%b rdata=%h want 1/12345678", m0_mem_ready, m0_mem_rdata);
    end
    checks++;
    if (m1_mem_ready !== 1'b0 || m1_mem_rdata !== 32'h0) begin
      errors++; $display("FAIL rd_other_master: m1 ready=%b rdata=%h want 0/0", m1_mem_ready, m1_mem_rdata);
    end
    tick();
    s_mem_ready = 0; s_mem_rdata = 0; m0_mem_valid = 0;
    #1;
    checks++;
    if (m0_mem_ready !== 1'b0 || s_mem_valid !== 1'b0) begin
      errors++; $display("FAIL rd_pulse_end: ready=%b s_valid=%b want 0/0", m0_mem_ready, s_mem_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr;
    logic        exp_m1;
    rst_n = 0;
    #3;
    rst_n = 1;
    m0_mem_addr = 32'h1000; m1_mem_addr = 32'h2000;
    m0_mem_valid = 1; m1_mem_valid = 1;
    for (int k = 0; k < 4; k++) begin
      exp_m1   = (k % 2 == 1);
      exp_addr = exp_m1 ? 32'h2000 : 32'h1000;
      #1;
      checks++;
      if (s_mem_valid !== 1'b0) begin
        errors++; $display("FAIL rr_idle_gap%0d: s_mem_valid=%b want 0", k, s_mem_valid);
      end
      tick(); #1;
      checks++;
      if (s_mem_valid !== 1'b1 || s_mem_addr !== exp_addr) begin
        errors++; $display("FAIL rr_grant%0d: v=%b addr=%h want 1/%h", k, s_mem_valid, s_mem_addr, exp_addr);
      end
      s_mem_ready = 1; s_mem_rdata = 32'hA0 + k;
      #1;
      checks++;
      if ({m1_mem_ready, m0_mem_ready} !== (exp_m1 ? 2'b10 : 2'b01) ||
          (exp_m1 ? m1_mem_rdata : m0_mem_rdata) !== 32'hA0 + k) begin
        errors++; $display("FAIL rr_ready%0d: r1r0=%b%b d0=%h d1=%h want m%0d with %h", k,
                           m1_mem_ready, m0_mem_ready, m0_mem_rdata, m1_mem_rdata, exp_m1, 32'hA0 + k);
      end
      tick();
      s_mem_ready = 0; s_mem_rdata = 0;
    end
    m0_mem_valid = 0; m1_mem_valid = 0;
    tick();
  endtask

  task automatic test_write_m1();
    m0_mem_addr = 32'h11111111; m0_mem_wdata = 32'h22222222; m0_mem_wstrb = 4'hF;
    m1_mem_addr = 32'h90000000; m1_mem_wdata = 32'h41; m1_mem_wstrb = 4'b0011;
    m1_mem_valid = 1;
    #1;
    checks++;
    if (s_mem_wstrb !== 4'h0 || s_mem_valid !== 1'b0) begin
      errors++; $display("FAIL wr_idle_wstrb: wstrb=%h v=%b want 0/0", s_mem_wstrb, s_mem_valid);
    end
    tick(); #1;
    checks++;
    if (s_mem_valid !== 1'b1 || s_mem_addr !== 32'h90000000 || s_mem_wdata !== 32'h41 || s_mem_wstrb !== 4'b0011) begin
      errors++; $display("FAIL wr_slave_req: v=%b a=%h w=%h s=%h want 1/90000000/00000041/3",
                         s_mem_valid, s_mem_addr, s_mem_wdata, s_mem_wstrb);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      checks++;
      if (s_mem_valid !== 1'b1 || m1_mem_ready !== 1'b0) begin
        errors++; $display("FAIL wr_hold%0d: v=%b ready=%b want 1/0", i, s_mem_valid, m1_mem_ready);
      end
    end
    tick();
    s_mem_ready = 1;
    #1;
    checks++;
    if (m1_mem_ready !== 1'b1 || m0_mem_ready !== 1'b0) begin
      errors++; $display("FAIL wr_complete: r1=%b r0=%b want 1/0", m1_mem_ready, m0_mem_ready);
    end
    tick();
    s_mem_ready = 0; m1_mem_valid = 0;
    #1;
    checks++;
    if (s_mem_wstrb !== 4'h0 || s_mem_valid !== 1'b0) begin
      errors++; $display("FAIL wr_after_wstrb: wstrb=%h v=%b want 0/0", s_mem_wstrb, s_mem_valid);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr;
    int          t_req;
    int          waited;
    m0_mem_addr = 32'h3000; m1_mem_addr = 32'h4000;
    m0_mem_valid = 1; m1_mem_valid = 1;
    t_req = cyc;
    for (int j = 0; j < 3; j++) begin
      exp_addr = (j == 1) ? 32'h4000 : 32'h3000;
      waited = 0;
      #1;
      while (s_mem_valid !== 1'b1 && waited < 6) begin
        tick(); #1;
        waited++;
      end
      checks++;
      if (s_mem_valid !== 1'b1 || s_mem_addr !== exp_addr) begin
        errors++; $display("FAIL b2b_order%0d: v=%b addr=%h want 1/%h", j, s_mem_valid, s_mem_addr, exp_addr);
      end
      if (j == 1) begin
        checks++;
        if (cyc - t_req > 4) begin
          errors++; $display("FAIL b2b_m1_wait: waited %0d cycles, want at most 4", cyc - t_req);
        end
      end
      tick();
      s_mem_ready = 1; s_mem_rdata = 32'hB0 + j;
      #1;
      checks++;
      if ((j == 1 ? m1_mem_ready : m0_mem_ready) !== 1'b1) begin
        errors++; $display("FAIL b2b_ready%0d: r0=%b r1=%b want grantee ready", j, m0_mem_ready, m1_mem_ready);
      end
      tick();
      s_mem_ready = 0; s_mem_rdata = 0;
      if (j == 1) m1_mem_valid = 0;
      if (j == 2) m0_mem_valid = 0;
    end
    tick();
  endtask

  task automatic test_abort();
    m1_mem_addr = 32'h5000; m1_mem_valid = 1;
    tick(); #1;
    checks++;
    if (s_mem_valid !== 1'b1 || s_mem_addr !== 32'h5000) begin
      errors++; $display("FAIL abort_grant: v=%b addr=%h want 1/00005000", s_mem_valid, s_mem_addr);
    end
    tick();
    m1_mem_valid = 0;
    #1;
    checks++;
    if (s_mem_valid !== 1'b0 || m1_mem_ready !== 1'b0) begin
      errors++; $display("FAIL abort_drop: v=%b ready=%b want 0/0", s_mem_valid, m1_mem_ready);
    end
    tick();
    m0_mem_addr = 32'h6000; m0_mem_valid = 1; m1_mem_valid = 1;
    #1;
    checks++;
    if (s_mem_valid !== 1'b0) begin
      errors++; $display("FAIL abort_idle: s_mem_valid=%b want 0", s_mem_valid);
    end
    tick(); #1;
    checks++;
    if (s_mem_addr !== 32'h5000) begin
      errors++; $display("FAIL abort_last_gnt: addr=%h want 00005000 (m1 still due)", s_mem_addr);
    end
    s_mem_ready = 1;
    #1;
    checks++;
    if (m1_mem_ready !== 1'b1) begin
      errors++; $display("FAIL abort_retry_done: m1 ready=%b want 1", m1_mem_ready);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    m0_mem_addr = 32'h7000; m0_mem_valid = 1;
    tick(); #1;
`ifdef MEMARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (s_mem_valid !== 1'b1 || m0_mem_ready !== 1'b0 || bus_err !== 1'b0) begin
        errors++; $display("FAIL to_wait%0d: v=%b ready=%b err=%b want 1/0/0", i, s_mem_valid, m0_mem_ready, bus_err);
      end
      tick(); #1;
    end
    checks++;
    if (m0_mem_ready !== 1'b1 || m0_mem_rdata !== 32'hDEADBEEF || bus_err !== 1'b1 || s_mem_valid !== 1'b0) begin
      errors++; $display("FAIL to_fire: ready=%b rdata=%h err=%b v=%b want 1/deadbeef/1/0",
                         m0_mem_ready, m0_mem_rdata, bus_err, s_mem_valid);
    end
    tick();
    m0_mem_valid = 0;
    #1;
    checks++;
    if (bus_err !== 1'b0 || m0_mem_ready !== 1'b0) begin
      errors++; $display("FAIL to_pulse: err=%b ready=%b want 0/0", bus_err, m0_mem_ready);
    end
    tick();
    m0_mem_valid = 1;
    tick(); #1;
    for (int i = 0; i < 15; i++) begin
      tick(); #1;
    end
    s_mem_ready = 1; s_mem_rdata = 32'h5555AAAA;
    #1;
    checks++;
    if (m0_mem_ready !== 1'b1 || m0_mem_rdata !== 32'h5555AAAA || bus_err !== 1'b0) begin
      errors++; $display("FAIL to_race: ready=%b rdata=%h err=%b want 1/5555aaaa/0",
                         m0_mem_ready, m0_mem_rdata, bus_err);
    end
`else
    for (int i = 0; i < 200; i++) begin
      checks++;
      if (s_mem_valid !== 1'b1 || m0_mem_ready !== 1'b0 || bus_err !== 1'b0) begin
        errors++; $display("FAIL nto_wait%0d: v=%b ready=%b err=%b want 1/0/0", i, s_mem_valid, m0_mem_ready, bus_err);
      end
      tick(); #1;
    end
    s_mem_ready = 1; s_mem_rdata = 32'h5555AAAA;
    #1;
    checks++;
    if (m0_mem_ready !== 1'b1 || m0_mem_rdata !== 32'h5555AAAA) begin
      errors++; $display("FAIL nto_done: ready=%b rdata=%h want 1/5555aaaa", m0_mem_ready, m0_mem_rdata);
    end
`endif
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    m0_mem_addr = 32'h8000; m0_mem_wdata = 32'h1; m0_mem_wstrb = 4'hF; m0_mem_valid = 1;
    tick(); #1;
    checks++;
    if (s_mem_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_grant: s_mem_valid=%b want 1", s_mem_valid);
    end
    #1;
    rst_n = 0; s_mem_ready = 1; s_mem_rdata = 32'hCAFEF00D;
    #1;
    checks++;
    if ({s_mem_valid, s_mem_addr, s_mem_wdata, s_mem_wstrb} !== 69'd0 ||
        {m0_mem_ready, m1_mem_ready, m0_mem_rdata, m1_mem_rdata, bus_err} !== 67'd0) begin
      errors++; $display("FAIL rstmid_outputs: v=%b a=%h w=%h s=%h r0=%b d0=%h err=%b want all 0",
                         s_mem_valid, s_mem_addr, s_mem_wdata, s_mem_wstrb, m0_mem_ready, m0_mem_rdata, bus_err);
    end
    idle_inputs();
    tick(); tick();
    rst_n = 1;
    m0_mem_addr = 32'h9000; m1_mem_addr = 32'hA000;
    m0_mem_valid = 1; m1_mem_valid = 1;
    #1;
    checks++;
    if (s_mem_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: s_mem_valid=%b want 0", s_mem_valid);
    end
    tick(); #1;
    checks++;
    if (s_mem_valid !== 1'b1 || s_mem_addr !== 32'h9000) begin
      errors++; $display("FAIL rstmid_first_gnt: v=%b addr=%h want 1/00009000", s_mem_valid, s_mem_addr);
    end
    s_mem_ready = 1;
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_read_m0();
    test_round_robin();
    test_write_m1();
    test_back_to_back();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
